value_accumulator: RTL and testbench
====================================

// Module: value_accumulator
// PURPOSE
//  - Downstream consumer of the 10-bit constant/data values produced by the package-import stage.
//  - Accepts a valid/ready stream of DATA_WIDTH-bit operands and sums each group of COUNT beats.
//  - Emits each group's sum plus an over-threshold flag on a registered valid/ready output.
//  - The threshold comes from the shared package.
// PARAMETERS
//  DATA_WIDTH  10  operand width; matches the upstream 10-bit values
//  COUNT       4   operands per group; legal range 2..256
//  ACC_WIDTH   12  accumulator/result width; must be >= DATA_WIDTH
// PORTS
//  i_clk    in   1           clock, rising edge
//  i_rst_n  in   1           reset, asynchronous assert, active-low
//  i_valid  in   1           input operand valid
//  o_ready  out  1           block accepts an operand this cycle
//  i_data   in   DATA_WIDTH  operand, unsigned
//  o_valid  out  1           result valid
//  i_ready  in   1           downstream accepts the result
//  o_sum    out  ACC_WIDTH   group sum
//  o_over   out  1           o_sum > value_accumulator_pkg::THRESHOLD
// BEHAVIOUR
//  - Clock/reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
//  - Reset values: state=ACCUM, acc=0, cnt=0, o_valid=0, o_sum=0, o_over=0. o_ready=1 after reset.
//  - In-handshake: i_valid & o_ready. Out-handshake: o_valid & i_ready.
//  - FSM, 2 states:
//    - ACCUM:
//      - o_ready=1, o_valid=0.
//      - Each in-handshake: acc <= acc + zero-extended i_data; cnt <= cnt + 1.
//      - In-handshake with cnt==COUNT-1: o_sum <= acc+i_data, o_over <= (acc+i_data) > THRESHOLD,
//        acc <= 0, cnt <= 0, go to EMIT.
//    - EMIT:
//      - o_ready=0, o_valid=1.
//      - o_sum and o_over are held stable while i_ready=0.
//      - Out-handshake: go to ACCUM; o_valid drops the next cycle.
//  - Latency: o_valid rises on the cycle after the COUNT-th accepted beat.
//    Throughput is COUNT+1 cycles per group at full rate; no overlap of EMIT and ACCUM.
//  - i_data is ignored when there is no in-handshake; gaps in i_valid do not disturb acc/cnt.
//  - Overflow rule: ACC_WIDTH-bit add, behaviour set by CONFIGURATION. o_over compares the stored
//    (wrapped or saturated) result.
//  - THRESHOLD is an int unsigned; compare after zero-extending o_sum to 32 bits.
//  - Reset mid-group or mid-EMIT: partial sum and pending result are discarded; all reset values apply.
//  - o_ready and o_valid are decoded from registered state only; no combinational path from i_* to o_*.
// CONFIGURATION
//  - VALUE_ACCUMULATOR_SAT_EN defined: the add saturates at 2^ACC_WIDTH-1 and stays there for the
//    rest of the group.
//  - Not defined: the add wraps modulo 2^ACC_WIDTH.
//  - The ports are identical in both builds.
// STRUCTURE
//  - Package value_accumulator_pkg:
//    - localparam int unsigned THRESHOLD = 512
//    - localparam int unsigned DATA_WIDTH_DEF = 10
//    - typedef enum logic {ACCUM, EMIT} state_t
//    - The module imports THRESHOLD explicitly and state_t via wildcard.
//  - Sub-module value_accumulator_add:
//    - Combinational ACC_WIDTH adder.
//    - Contains the VALUE_ACCUMULATOR_SAT_EN wrap/saturate selection.
//    - Instanced once.
//  - Top level holds the FSM, cnt ($clog2(COUNT) bits), acc and the output registers.
// TESTING
//  1. Defaults; beats 100,200,300,400 at full rate, i_ready=1 -> o_sum=1000, o_over=1;
//     o_valid rises 1 cycle after the 4th beat.
//  2. Beats 1,2,3,4 -> o_sum=10, o_over=0. Beats 128x4 -> o_sum=512, o_over=0.
//     Beats 128,128,128,129 -> o_sum=513, o_over=1.
//  3. i_ready=0 for 3 cycles in EMIT -> o_valid=1, o_ready=0, o_sum stable throughout;
//     i_valid beats during EMIT are not accepted.
//  4. COUNT=8, beats 1023x8:
//     - without SAT_EN -> o_sum=4088, o_over=1
//     - with SAT_EN -> o_sum=4095
//  5. i_valid toggled 1/0 every cycle -> same sums as full-rate runs; cnt advances only on handshakes.
//  6. Reset after 2 of 4 beats (async, mid-cycle) -> o_valid=0, o_ready=1 immediately.
//     Then 4 beats of 1 -> o_sum=4.

Source files
------------

// File: rtl/value_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// value_accumulator_pkg
// Shared constants and types for the value accumulator.
//   THRESHOLD      : a group sum strictly above this value raises o_over
//   DATA_WIDTH_DEF : width of the upstream operand stream
//   state_t        : two-state control FSM encoding (ACCUM, EMIT)
// -----------------------------------------------------------------------------
package value_accumulator_pkg;

   localparam int unsigned THRESHOLD      = 32'd512;
   localparam int unsigned DATA_WIDTH_DEF = 32'd10;

   typedef enum logic {
      ACCUM = 1'b0,
      EMIT  = 1'b1
   } state_t;

endpackage : value_accumulator_pkg

// File: rtl/value_accumulator_add.sv
// -----------------------------------------------------------------------------
// value_accumulator_add
// Combinational ACC_WIDTH-bit adder: running accumulator plus one unsigned
// operand (zero-extended).
//   Build option VALUE_ACCUMULATOR_SAT_EN:
//     defined   -> result saturates at 2^ACC_WIDTH-1
//     undefined -> result wraps modulo 2^ACC_WIDTH
// Ports
//   a_i   in  ACC_WIDTH   current accumulator value
//   b_i   in  DATA_WIDTH  operand, unsigned
//   sum_o out ACC_WIDTH   wrapped or saturated sum
// -----------------------------------------------------------------------------
module value_accumulator_add #(
   parameter int unsigned DATA_WIDTH = 10,
   parameter int unsigned ACC_WIDTH  = 12
) (
   input  logic [ACC_WIDTH-1:0]  a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [ACC_WIDTH-1:0]  sum_o
);

`ifdef VALUE_ACCUMULATOR_SAT_EN
   // One extra bit catches the carry out; since both operands are unsigned,
   // a saturated accumulator can only stay saturated for the rest of a group.
   logic [ACC_WIDTH:0] full_s;

   // Saturating add
   always_comb begin
      full_s = {1'b0, a_i} + (ACC_WIDTH + 1)'(b_i);
      if (full_s[ACC_WIDTH]) begin
         sum_o = {ACC_WIDTH{1'b1}};
      end else begin
         sum_o = full_s[ACC_WIDTH-1:0];
      end
   end
`else
   // Wrapping add: the carry out is simply dropped
   always_comb begin
      sum_o = a_i + ACC_WIDTH'(b_i);
   end
`endif

endmodule : value_accumulator_add

// File: rtl/value_accumulator.sv
// -----------------------------------------------------------------------------
// value_accumulator
// Sums each group of COUNT accepted operands from a valid/ready stream and
// presents the group sum with an over-threshold flag on a registered
// valid/ready output. Accumulation and emission never overlap: the block stops
// accepting operands while a result is pending.
// Build option VALUE_ACCUMULATOR_SAT_EN selects a saturating accumulator
// (default build wraps); ports are identical in both builds.
// Ports
//   i_clk    in   1           clock, rising edge
//   i_rst_n  in   1           asynchronous active-low reset
//   i_valid  in   1           operand valid
//   o_ready  out  1           operand accepted this cycle when i_valid=1
//   i_data   in   DATA_WIDTH  operand, unsigned
//   o_valid  out  1           result valid
//   i_ready  in   1           downstream accepts the result
//   o_sum    out  ACC_WIDTH   group sum
//   o_over   out  1           o_sum > THRESHOLD
// -----------------------------------------------------------------------------
module value_accumulator #(
   parameter int unsigned DATA_WIDTH = 10,
   parameter int unsigned COUNT      = 4,
   parameter int unsigned ACC_WIDTH  = 12
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [ACC_WIDTH-1:0]  o_sum,
   output logic                  o_over
);

   import value_accumulator_pkg::THRESHOLD;
   import value_accumulator_pkg::*;

   localparam int unsigned           CNT_W    = (COUNT > 32'd1) ? $clog2(COUNT) : 32'd1;
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(COUNT - 32'd1);

   state_t                 state_q, state_d;
   logic [ACC_WIDTH-1:0]   acc_q,   acc_d;
   logic [CNT_W-1:0]       cnt_q,   cnt_d;
   logic [ACC_WIDTH-1:0]   sum_q,   sum_d;
   logic                   over_q,  over_d;
   logic [ACC_WIDTH-1:0]   add_sum_s;
   logic                   in_hs_s;

   value_accumulator_add #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_add (
      .a_i   (acc_q),
      .b_i   (i_data),
      .sum_o (add_sum_s)
   );

   // Handshake qualifiers come from registered state only, so there is no
   // combinational path from any input to o_ready / o_valid.
   assign o_ready = (state_q == ACCUM);
   assign o_valid = (state_q == EMIT);
   assign o_sum   = sum_q;
   assign o_over  = over_q;
   assign in_hs_s = i_valid & o_ready;

   // Next-state and datapath update for the ACCUM/EMIT control FSM
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      over_d  = over_q;
      case (state_q)
         ACCUM: begin
            if (in_hs_s) begin
               if (cnt_q == CNT_LAST) begin
                  // Last beat of the group: capture the (wrapped or
                  // saturated) result and clear the running sum.
                  sum_d   = add_sum_s;
                  over_d  = (32'(add_sum_s) > THRESHOLD);
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = EMIT;
               end else begin
                  acc_d   = add_sum_s;
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ACCUM;
            end
         end
         EMIT: begin
            // o_sum / o_over are held because sum_d/over_d default to hold
            if (i_ready) begin
               state_d = ACCUM;
            end else begin
               state_d = EMIT;
            end
         end
         default: begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // State, accumulator, beat counter and output registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         over_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         over_q  <= over_d;
      end
   end

endmodule : value_accumulator

// File: tb/tb_value_accumulator.sv
// -----------------------------------------------------------------------------
// tb_value_accumulator
// Randomised and directed stimulus for value_accumulator with a queue-based
// scoreboard. A second instance with COUNT=8 exercises accumulator overflow.
// Honors VALUE_ACCUMULATOR_SAT_EN when computing expected sums.
// -----------------------------------------------------------------------------
module tb_value_accumulator;

   import value_accumulator_pkg::*;

   localparam int unsigned DW   = 10;
   localparam int unsigned AW   = 12;
   localparam int unsigned AMAX = (1 << AW) - 1;

   typedef struct {
      int unsigned sum;
      logic        over;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_valid, i_ready, o_ready, o_valid, o_over;
   logic [DW-1:0] i_data;
   logic [AW-1:0] o_sum;

   logic          b_valid, b_ready_in, b_ready, b_ovalid, b_over;
   logic [DW-1:0] b_data;
   logic [AW-1:0] b_sum;

   int            errors = 0;
   int            checks = 0;
   int            rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random
   exp_t          exp_q[$];
   int unsigned   beats[$];       // operands accepted so far in the current group
   logic [DW-1:0] g8[8];

   always #5 clk = ~clk;

   value_accumulator #(.DATA_WIDTH(DW), .COUNT(4), .ACC_WIDTH(AW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready),
      .o_sum(o_sum), .o_over(o_over)
   );

   value_accumulator #(.DATA_WIDTH(DW), .COUNT(8), .ACC_WIDTH(AW)) dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .o_ready(b_ready),
      .i_data(b_data), .o_valid(b_ovalid), .i_ready(b_ready_in),
      .o_sum(b_sum), .o_over(b_over)
   );

   // Reference rule for a group: exact integer sum, then wrap or saturate
   function automatic int unsigned ref_sum(input int unsigned exact);
`ifdef VALUE_ACCUMULATOR_SAT_EN
      return (exact > AMAX) ? AMAX : exact;
`else
      return exact % (AMAX + 1);
`endif
   endfunction

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: when the group is complete, push its expected result
   task automatic model_accept(input int unsigned d);
      int unsigned tot;
      exp_t        e;
      beats.push_back(d);
      if (beats.size() == 4) begin
         tot = 0;
         foreach (beats[k]) tot += beats[k];
         e.sum  = ref_sum(tot);
         e.over = (e.sum > THRESHOLD);
         exp_q.push_back(e);
         beats.delete();
      end
   endtask

   // Present one operand and hold it until accepted (bounded)
   task automatic send(input logic [DW-1:0] d);
      logic rd;
      bit   ok;
      ok      = 1'b0;
      i_valid = 1'b1;
      i_data  = d;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         rd = o_ready;
         @(posedge clk);
         #1;
         if (rd) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_timeout: got no accept expected accept of %0d", d);
      end else begin
         model_accept(32'(d));
      end
   endtask

   task automatic idle(input int n);
      i_valid = 1'b0;
      i_data  = DW'($urandom);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one COUNT=8 group from g8 and check the presented result
   task automatic group8(input string name);
      logic        rd;
      int unsigned tot, e;
      tot = 0;
      for (int k = 0; k < 8; k++) begin
         b_valid = 1'b1;
         b_data  = g8[k];
         tot    += 32'(g8[k]);
         for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            rd = b_ready;
            @(posedge clk);
            #1;
            if (rd) break;
         end
      end
      b_valid = 1'b0;
      e = ref_sum(tot);
      @(negedge clk);
      check({name, "_valid"}, 32'(b_ovalid), 32'd1);
      check({name, "_sum"},   32'(b_sum),    e);
      check({name, "_over"},  32'(b_over),   32'(e > THRESHOLD));
   endtask

   // Downstream ready generator
   initial begin
      i_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = 1'b0;
            default: i_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pop and compare on every output handshake, check hold stability
   initial begin
      exp_t          e;
      logic          prev_hold;
      logic [AW-1:0] prev_sum;
      prev_hold = 1'b0;
      prev_sum  = '0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            prev_hold = 1'b0;
         end else begin
            if (o_valid) begin
               check("valid_excl_ready", 32'(o_ready), 32'd0);
               if (prev_hold) check("hold_stable", 32'(o_sum), 32'(prev_sum));
            end
            if (o_valid && i_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result: got sum %0d expected no output", o_sum);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_sum",  32'(o_sum),  e.sum);
                  check("sb_over", 32'(o_over), 32'(e.over));
               end
            end
            prev_hold = o_valid && !i_ready;
            prev_sum  = o_sum;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      i_valid    = 1'b0;
      i_data     = '0;
      b_valid    = 1'b0;
      b_data     = '0;
      b_ready_in = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_sum",   32'(o_sum),   32'd0);
      check("rst_over",  32'(o_over),  32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full rate group with latency check
      send(10'd100); send(10'd200); send(10'd300);
      check("lat_before", 32'(o_valid), 32'd0);
      send(10'd400);
      check("lat_valid", 32'(o_valid), 32'd1);
      check("lat_sum",   32'(o_sum),   32'd1000);
      check("lat_over",  32'(o_over),  32'd1);

      // Threshold boundaries
      send(10'd1);   send(10'd2);   send(10'd3);   send(10'd4);
      send(10'd128); send(10'd128); send(10'd128); send(10'd128);
      send(10'd128); send(10'd128); send(10'd128); send(10'd129);
      idle(3);

      // Back-pressure in EMIT; i_valid held high must not be accepted
      rdy_mode = 1;
      idle(2);
      send(10'd7); send(10'd8); send(10'd9); send(10'd10);
      i_valid = 1'b1;
      i_data  = 10'd999;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_valid", 32'(o_valid), 32'd1);
         check("bp_ready", 32'(o_ready), 32'd0);
         check("bp_sum",   32'(o_sum),   32'd34);
      end
      rdy_mode = 0;
      idle(3);
      check("bp_drained", 32'(exp_q.size()), 32'd0);

      // i_valid toggling every cycle
      for (int k = 0; k < 8; k++) begin
         send(DW'($urandom_range(0, 1023)));
         idle(1);
      end

      // Randomised traffic with random back-pressure and gaps
      rdy_mode = 2;
      for (int k = 0; k < 160; k++) begin
         if ($urandom_range(0, 1) == 0) send(DW'($urandom_range(0, 255)));
         else                           send(DW'($urandom_range(0, 1023)));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      i_valid  = 1'b0;
      rdy_mode = 0;
      for (int n = 0; n < 50 && exp_q.size() != 0; n++) idle(1);
      check("rand_drained", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset mid-group
      send(10'd50); send(10'd60);
      i_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      check("rstg_valid", 32'(o_valid), 32'd0);
      check("rstg_ready", 32'(o_ready), 32'd1);
      beats.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(10'd1); send(10'd1); send(10'd1); send(10'd1);
      idle(3);

      // Asynchronous reset while a result is pending
      rdy_mode = 1;
      idle(2);
      send(10'd300); send(10'd300); send(10'd300); send(10'd300);
      i_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rste_valid", 32'(o_valid), 32'd0);
      check("rste_ready", 32'(o_ready), 32'd1);
      check("rste_sum",   32'(o_sum),   32'd0);
      exp_q.delete();
      beats.delete();
      rdy_mode = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(10'd2); send(10'd3); send(10'd5); send(10'd7);
      idle(3);
      check("final_drained", 32'(exp_q.size()), 32'd0);

      // COUNT=8 instance: overflow behaviour
      foreach (g8[k]) g8[k] = 10'd1023;
      group8("c8_max");
      foreach (g8[k]) g8[k] = (k < 5) ? 10'd1023 : 10'd0;
      g8[7] = 10'd1;
      group8("c8_mid");
      foreach (g8[k]) g8[k] = DW'($urandom_range(0, 1023));
      group8("c8_rand");
      foreach (g8[k]) g8[k] = 10'd64;
      group8("c8_thr");
      repeat (3) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_value_accumulator
